// File: rtl/mips_pkg.sv
// Shared MIPS pipeline types: widths, ALU op codes and
// the decoded control bundle carried from ID into EX.
package mips_pkg;

  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 6;
  localparam int ALUOP_W = 4;

  localparam logic [ALUOP_W-1:0] ALU_ADD = 4'd0;
  localparam logic [ALUOP_W-1:0] ALU_SUB = 4'd1;
  localparam logic [ALUOP_W-1:0] ALU_AND = 4'd2;
  localparam logic [ALUOP_W-1:0] ALU_OR  = 4'd3;
  localparam logic [ALUOP_W-1:0] ALU_XOR = 4'd4;
  localparam logic [ALUOP_W-1:0] ALU_SLT = 4'd5;
  localparam logic [ALUOP_W-1:0] ALU_SLL = 4'd6;
  localparam logic [ALUOP_W-1:0] ALU_SRL = 4'd7;
  localparam logic [ALUOP_W-1:0] ALU_SRA = 4'd8;
  localparam logic [ALUOP_W-1:0] ALU_LUI = 4'd9;

  typedef struct packed {
    logic               reg_write;
    logic               mem_read;
    logic               mem_write;
    logic               mem_to_reg;
    logic               alu_src;
    logic [ALUOP_W-1:0] alu_op;
  } ex_ctrl_t;

  localparam ex_ctrl_t EX_CTRL_NOP = '0;

endpackage

// File: rtl/wb_bypass_mux.sv
// Register read operand select: forwards same-cycle
// write-back data around the register file; r0 reads 0.
module wb_bypass_mux #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 6
) (
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              wb_write,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] data
);

  always_comb begin
    data = rd_data;
    if (rd_addr == '0)
      data = '0;
    else if (wb_write && (wb_addr == rd_addr))
      data = wb_data;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with write-back bypass,
// load-use bubble insertion and a saturating bubble count.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int DATA_W  = mips_pkg::DATA_W,
  parameter int ADDR_W  = mips_pkg::ADDR_W,
  parameter int ALUOP_W = mips_pkg::ALUOP_W,
  parameter int CNT_W   = 32
) (
  input  logic               SYS_clk,
  input  logic               SYS_rst_n,
  input  logic               ID_valid,
  input  logic [ADDR_W-1:0]  ID_rs,
  input  logic [ADDR_W-1:0]  ID_rt,
  input  logic [ADDR_W-1:0]  ID_rd,
  input  logic               ID_uses_rt,
  input  logic [DATA_W-1:0]  ID_imm,
  input  logic [DATA_W-1:0]  ID_pc,
  input  logic               ID_reg_write,
  input  logic               ID_mem_read,
  input  logic               ID_mem_write,
  input  logic               ID_mem_to_reg,
  input  logic               ID_alu_src,
  input  logic [ALUOP_W-1:0] ID_alu_op,
  input  logic [DATA_W-1:0]  REG_data_out1,
  input  logic [DATA_W-1:0]  REG_data_out2,
  input  logic               WB_write,
  input  logic [ADDR_W-1:0]  WB_address,
  input  logic [DATA_W-1:0]  WB_data,
  input  logic               EX_stall,
  input  logic               EX_flush,
  output logic               ID_stall,
  output logic               EX_valid,
  output logic [DATA_W-1:0]  EX_rs_data,
  output logic [DATA_W-1:0]  EX_rt_data,
  output logic [ADDR_W-1:0]  EX_rs,
  output logic [ADDR_W-1:0]  EX_rt,
  output logic [ADDR_W-1:0]  EX_rd,
  output logic [DATA_W-1:0]  EX_imm,
  output logic [DATA_W-1:0]  EX_pc,
  output logic               EX_reg_write,
  output logic               EX_mem_read,
  output logic               EX_mem_write,
  output logic               EX_mem_to_reg,
  output logic               EX_alu_src,
  output logic [ALUOP_W-1:0] EX_alu_op,
  output logic [31:0]        STALL_count
);

  ex_ctrl_t          id_ctrl;
  ex_ctrl_t          ctrl_q;
  logic              valid_q;
  logic [DATA_W-1:0] rs_in;
  logic [DATA_W-1:0] rt_in;
  logic [CNT_W-1:0]  cnt_q;
  logic              hazard;
  logic              rs_hit;
  logic              rt_hit;
  logic              wb_live;

  assign id_ctrl = '{
    reg_write:  ID_reg_write,
    mem_read:   ID_mem_read,
    mem_write:  ID_mem_write,
    mem_to_reg: ID_mem_to_reg,
    alu_src:    ID_alu_src,
    alu_op:     ID_alu_op
  };

  wb_bypass_mux #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_rs_byp (
    .rd_addr (ID_rs),
    .rd_data (REG_data_out1),
    .wb_write(WB_write),
    .wb_addr (WB_address),
    .wb_data (WB_data),
    .data    (rs_in)
  );

  wb_bypass_mux #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_rt_byp (
    .rd_addr (ID_rt),
    .rd_data (REG_data_out2),
    .wb_write(WB_write),
    .wb_addr (WB_address),
    .wb_data (WB_data),
    .data    (rt_in)
  );

  assign rs_hit = (EX_rd == ID_rs);
  assign rt_hit = ID_uses_rt && (EX_rd == ID_rt);

  assign hazard = ID_valid && valid_q &&
                  ctrl_q.mem_read &&
                  (EX_rd != '0) &&
                  (rs_hit || rt_hit);

  assign ID_stall = hazard || EX_stall;

  // A held stage still has to observe write-backs to its sources.
  assign wb_live = WB_write && (WB_address != '0);

  always_ff @(posedge SYS_clk or negedge SYS_rst_n) begin
    if (!SYS_rst_n) begin
      valid_q    <= 1'b0;
      ctrl_q     <= EX_CTRL_NOP;
      EX_rs_data <= '0;
      EX_rt_data <= '0;
      EX_rs      <= '0;
      EX_rt      <= '0;
      EX_rd      <= '0;
      EX_imm     <= '0;
      EX_pc      <= '0;
      cnt_q      <= '0;
    end else if (EX_flush) begin
      valid_q <= 1'b0;
      ctrl_q  <= EX_CTRL_NOP;
    end else if (EX_stall) begin
      if (wb_live && (WB_address == EX_rs))
        EX_rs_data <= WB_data;
      if (wb_live && (WB_address == EX_rt))
        EX_rt_data <= WB_data;
    end else if (hazard) begin
      valid_q <= 1'b0;
      ctrl_q  <= EX_CTRL_NOP;
      if (~&cnt_q)
        cnt_q <= cnt_q + CNT_W'(1);
    end else begin
      valid_q    <= ID_valid;
      ctrl_q     <= ID_valid ? id_ctrl : EX_CTRL_NOP;
      EX_rs_data <= rs_in;
      EX_rt_data <= rt_in;
      EX_rs      <= ID_rs;
      EX_rt      <= ID_rt;
      EX_rd      <= ID_rd;
      EX_imm     <= ID_imm;
      EX_pc      <= ID_pc;
    end
  end

  assign EX_valid      = valid_q;
  assign EX_reg_write  = ctrl_q.reg_write;
  assign EX_mem_read   = ctrl_q.mem_read;
  assign EX_mem_write  = ctrl_q.mem_write;
  assign EX_mem_to_reg = ctrl_q.mem_to_reg;
  assign EX_alu_src    = ctrl_q.alu_src;
  assign EX_alu_op     = ctrl_q.alu_op;
  assign STALL_count   = 32'(cnt_q);

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios
// plus random traffic against a behavioural model.
module tb_id_ex_stage;

  localparam int CNT_W   = 3;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic        SYS_clk = 1'b0;
  logic        SYS_rst_n;
  logic        ID_valid;
  logic [5:0]  ID_rs, ID_rt, ID_rd;
  logic        ID_uses_rt;
  logic [31:0] ID_imm, ID_pc;
  logic        ID_reg_write, ID_mem_read, ID_mem_write;
  logic        ID_mem_to_reg, ID_alu_src;
  logic [3:0]  ID_alu_op;
  logic [31:0] REG_data_out1, REG_data_out2;
  logic        WB_write;
  logic [5:0]  WB_address;
  logic [31:0] WB_data;
  logic        EX_stall, EX_flush;
  logic        ID_stall, EX_valid;
  logic [31:0] EX_rs_data, EX_rt_data;
  logic [5:0]  EX_rs, EX_rt, EX_rd;
  logic [31:0] EX_imm, EX_pc;
  logic        EX_reg_write, EX_mem_read, EX_mem_write;
  logic        EX_mem_to_reg, EX_alu_src;
  logic [3:0]  EX_alu_op;
  logic [31:0] STALL_count;

  int total = 0;
  int bad   = 0;

  always #5 SYS_clk = ~SYS_clk;

  id_ex_stage #(.CNT_W(CNT_W)) dut (
    .SYS_clk      (SYS_clk),
    .SYS_rst_n    (SYS_rst_n),
    .ID_valid     (ID_valid),
    .ID_rs        (ID_rs),
    .ID_rt        (ID_rt),
    .ID_rd        (ID_rd),
    .ID_uses_rt   (ID_uses_rt),
    .ID_imm       (ID_imm),
    .ID_pc        (ID_pc),
    .ID_reg_write (ID_reg_write),
    .ID_mem_read  (ID_mem_read),
    .ID_mem_write (ID_mem_write),
    .ID_mem_to_reg(ID_mem_to_reg),
    .ID_alu_src   (ID_alu_src),
    .ID_alu_op    (ID_alu_op),
    .REG_data_out1(REG_data_out1),
    .REG_data_out2(REG_data_out2),
    .WB_write     (WB_write),
    .WB_address   (WB_address),
    .WB_data      (WB_data),
    .EX_stall     (EX_stall),
    .EX_flush     (EX_flush),
    .ID_stall     (ID_stall),
    .EX_valid     (EX_valid),
    .EX_rs_data   (EX_rs_data),
    .EX_rt_data   (EX_rt_data),
    .EX_rs        (EX_rs),
    .EX_rt        (EX_rt),
    .EX_rd        (EX_rd),
    .EX_imm       (EX_imm),
    .EX_pc        (EX_pc),
    .EX_reg_write (EX_reg_write),
    .EX_mem_read  (EX_mem_read),
    .EX_mem_write (EX_mem_write),
    .EX_mem_to_reg(EX_mem_to_reg),
    .EX_alu_src   (EX_alu_src),
    .EX_alu_op    (EX_alu_op),
    .STALL_count  (STALL_count)
  );

  wire [187:0] obs_vec = {
    EX_valid, EX_reg_write, EX_mem_read, EX_mem_write,
    EX_mem_to_reg, EX_alu_src, EX_alu_op,
    EX_rs, EX_rt, EX_rd,
    EX_rs_data, EX_rt_data, EX_imm, EX_pc, STALL_count
  };

  // Model of what the stage should present downstream
  logic        m_valid;
  logic [8:0]  m_ctrl;
  logic [5:0]  m_rs, m_rt, m_rd;
  logic [31:0] m_rs_d, m_rt_d, m_imm, m_pc;
  int          m_cnt;
  logic        exp_stall, obs_stall;

  function automatic logic [187:0] exp_vec();
    return {m_valid, m_ctrl, m_rs, m_rt, m_rd,
            m_rs_d, m_rt_d, m_imm, m_pc, 32'(m_cnt)};
  endfunction

  function automatic logic [31:0] operand(
    input logic [5:0] a, input logic [31:0] rf);
    if (a == 0) return 0;
    if (WB_write && WB_address == a) return WB_data;
    return rf;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_ctrl = 0;
    m_rs = 0; m_rt = 0; m_rd = 0;
    m_rs_d = 0; m_rt_d = 0; m_imm = 0; m_pc = 0;
    m_cnt = 0;
  endtask

  task automatic model_step();
    logic lu;
    lu = ID_valid && m_valid && m_ctrl[7] && m_rd != 0 &&
         (m_rd == ID_rs || (ID_uses_rt && m_rd == ID_rt));
    exp_stall = lu || EX_stall;
    if (EX_flush) begin
      m_valid = 0; m_ctrl = 0;
    end else if (EX_stall) begin
      if (WB_write && WB_address != 0 && WB_address == m_rs)
        m_rs_d = WB_data;
      if (WB_write && WB_address != 0 && WB_address == m_rt)
        m_rt_d = WB_data;
    end else if (lu) begin
      m_valid = 0; m_ctrl = 0;
      if (m_cnt < CNT_MAX) m_cnt++;
    end else begin
      m_valid = ID_valid;
      m_ctrl = ID_valid ? {ID_reg_write, ID_mem_read,
               ID_mem_write, ID_mem_to_reg, ID_alu_src,
               ID_alu_op} : 9'd0;
      m_rs = ID_rs; m_rt = ID_rt; m_rd = ID_rd;
      m_rs_d = operand(ID_rs, REG_data_out1);
      m_rt_d = operand(ID_rt, REG_data_out2);
      m_imm = ID_imm; m_pc = ID_pc;
    end
  endtask

  task automatic tick();
    @(negedge SYS_clk);
    obs_stall = ID_stall;
    model_step();
    @(posedge SYS_clk);
    #1;
  endtask

  task automatic idle_inputs();
    ID_valid = 0; ID_rs = 0; ID_rt = 0; ID_rd = 0;
    ID_uses_rt = 0; ID_imm = 0; ID_pc = 0;
    ID_reg_write = 0; ID_mem_read = 0; ID_mem_write = 0;
    ID_mem_to_reg = 0; ID_alu_src = 0; ID_alu_op = 0;
    REG_data_out1 = 0; REG_data_out2 = 0;
    WB_write = 0; WB_address = 0; WB_data = 0;
    EX_stall = 0; EX_flush = 0;
  endtask

  task automatic load_word(input logic [5:0] rd);
    idle_inputs();
    ID_valid = 1; ID_rd = rd; ID_rs = 6'd1;
    ID_reg_write = 1; ID_mem_read = 1;
    ID_mem_to_reg = 1; ID_alu_src = 1;
    ID_imm = 32'h10; ID_pc = 32'h400;
  endtask

  task automatic test_reset();
    SYS_rst_n = 0;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge SYS_clk);
    #1;
    total++;
    if (obs_vec !== '0 || ID_stall !== 1'b0) begin
      bad++;
      $display("FAIL reset_state got=%h stall=%b want=0",
               obs_vec, ID_stall);
    end
    SYS_rst_n = 1;
  endtask

  task automatic test_capture();
    idle_inputs();
    ID_valid = 1; ID_rs = 9; ID_rt = 10; ID_rd = 3;
    REG_data_out1 = 10; REG_data_out2 = 11; ID_alu_op = 2;
    ID_imm = 32'hFFFF_FFF0; ID_pc = 32'h100;
    tick();
    total++;
    if ({EX_valid, EX_rs_data, EX_rt_data, EX_alu_op} !==
        {1'b1, 32'd10, 32'd11, 4'd2}) begin
      bad++;
      $display("FAIL capture got v=%b rs=%h rt=%h op=%h want 1/a/b/2",
               EX_valid, EX_rs_data, EX_rt_data, EX_alu_op);
    end
    total++;
    if (obs_vec !== exp_vec()) begin
      bad++;
      $display("FAIL capture_all got=%h want=%h", obs_vec, exp_vec());
    end
    #2 SYS_rst_n = 0;
    #1;
    total++;
    if (obs_vec !== '0) begin
      bad++;
      $display("FAIL async_reset got=%h want=0", obs_vec);
    end
    model_reset();
    @(posedge SYS_clk);
    #1 SYS_rst_n = 1;
  endtask

  task automatic test_bypass();
    idle_inputs();
    ID_valid = 1; ID_rs = 9; REG_data_out1 = 10;
    ID_rt = 12; REG_data_out2 = 32'h33;
    WB_write = 1; WB_address = 9; WB_data = 32'h55;
    tick();
    total++;
    if (EX_rs_data !== 32'h55 || EX_rt_data !== 32'h33) begin
      bad++;
      $display("FAIL bypass_hit got rs=%h rt=%h want 55/33",
               EX_rs_data, EX_rt_data);
    end
    ID_rs = 0; WB_address = 0; REG_data_out1 = 32'h99;
    ID_rt = 9; WB_address = 9;
    tick();
    total++;
    if (EX_rs_data !== 32'h0 || EX_rt_data !== 32'h55) begin
      bad++;
      $display("FAIL bypass_r0 got rs=%h rt=%h want 0/55",
               EX_rs_data, EX_rt_data);
    end
    WB_address = 0; ID_rt = 0; REG_data_out2 = 32'h77;
    tick();
    total++;
    if (EX_rt_data !== 32'h0) begin
      bad++;
      $display("FAIL bypass_wb0 got rt=%h want 0", EX_rt_data);
    end
  endtask

  task automatic test_load_use();
    int c0;
    c0 = m_cnt;
    load_word(6'd8);
    tick();
    idle_inputs();
    ID_valid = 1; ID_rs = 8; ID_rt = 3; ID_uses_rt = 1;
    ID_reg_write = 1; ID_rd = 4;
    #1;
    total++;
    if (ID_stall !== 1'b1) begin
      bad++;
      $display("FAIL load_use_stall got=%b want=1", ID_stall);
    end
    tick();
    total++;
    if ({EX_valid, EX_reg_write, STALL_count, ID_stall} !==
        {1'b0, 1'b0, 32'(c0 + 1), 1'b0}) begin
      bad++;
      $display("FAIL load_use_bubble got v=%b rw=%b cnt=%0d st=%b want 0/0/%0d/0",
               EX_valid, EX_reg_write, STALL_count, ID_stall, c0 + 1);
    end
    tick();
    load_word(6'd8);
    tick();
    idle_inputs();
    ID_valid = 1; ID_rs = 2; ID_rt = 8; ID_uses_rt = 0;
    #1;
    total++;
    if (ID_stall !== 1'b0) begin
      bad++;
      $display("FAIL no_rt_stall got=%b want=0", ID_stall);
    end
    tick();
    total++;
    if (obs_vec !== exp_vec()) begin
      bad++;
      $display("FAIL no_rt_capture got=%h want=%h", obs_vec, exp_vec());
    end
  endtask

  task automatic test_ex_stall();
    logic [187:0] held;
    idle_inputs();
    ID_valid = 1; ID_rs = 5; ID_rt = 10; ID_rd = 7;
    ID_uses_rt = 1; ID_reg_write = 1; ID_alu_op = 3;
    REG_data_out1 = 32'h44; REG_data_out2 = 32'h11;
    tick();
    held = obs_vec;
    for (int i = 1; i <= 3; i++) begin
      ID_rs = 6'(i); ID_rt = 6'(i + 20);
      REG_data_out1 = $urandom; EX_stall = 1;
      WB_write = (i == 2); WB_address = 10; WB_data = 32'h77;
      tick();
      total++;
      if (obs_stall !== 1'b1 || obs_vec !== exp_vec()) begin
        bad++;
        $display("FAIL ex_stall_c%0d got=%h st=%b want=%h st=1",
                 i, obs_vec, obs_stall, exp_vec());
      end
    end
    total++;
    if ({EX_rt_data, EX_rs_data, STALL_count, EX_valid} !==
        {32'h77, 32'h44, held[31:0], 1'b1}) begin
      bad++;
      $display("FAIL ex_stall_hold got rt=%h rs=%h cnt=%0d v=%b want 77/44/%0d/1",
               EX_rt_data, EX_rs_data, STALL_count, EX_valid, held[31:0]);
    end
  endtask

  task automatic test_flush();
    int c0;
    load_word(6'd8);
    tick();
    c0 = m_cnt;
    idle_inputs();
    ID_valid = 1; ID_rs = 8; EX_stall = 1; EX_flush = 1;
    tick();
    total++;
    if (obs_stall !== 1'b1 || EX_valid !== 1'b0 ||
        obs_vec[186:178] !== 9'd0 || STALL_count !== 32'(c0)) begin
      bad++;
      $display("FAIL flush got st=%b v=%b ctrl=%h cnt=%0d want 1/0/0/%0d",
               obs_stall, EX_valid, obs_vec[186:178], STALL_count, c0);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < CNT_MAX + 3; i++) begin
      load_word(6'd9);
      tick();
      idle_inputs();
      ID_valid = 1; ID_rt = 9; ID_uses_rt = 1;
      tick();
    end
    total++;
    if (STALL_count !== 32'(CNT_MAX) || obs_vec !== exp_vec()) begin
      bad++;
      $display("FAIL saturate got cnt=%0d want %0d", STALL_count, CNT_MAX);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      ID_valid = ($urandom_range(0, 9) < 8);
      ID_rs = 6'($urandom_range(0, 3));
      ID_rt = 6'($urandom_range(0, 3));
      ID_rd = 6'($urandom_range(0, 3));
      ID_uses_rt = $urandom_range(0, 1) == 1;
      ID_imm = $urandom; ID_pc = $urandom;
      ID_reg_write = $urandom_range(0, 1) == 1;
      ID_mem_read = $urandom_range(0, 1) == 1;
      ID_mem_write = $urandom_range(0, 1) == 1;
      ID_mem_to_reg = $urandom_range(0, 1) == 1;
      ID_alu_src = $urandom_range(0, 1) == 1;
      ID_alu_op = 4'($urandom_range(0, 15));
      REG_data_out1 = $urandom; REG_data_out2 = $urandom;
      WB_write = $urandom_range(0, 1) == 1;
      WB_address = 6'($urandom_range(0, 3));
      WB_data = $urandom;
      EX_stall = ($urandom_range(0, 4) == 0);
      EX_flush = ($urandom_range(0, 9) == 0);
      tick();
      total++;
      if (obs_vec !== exp_vec() || obs_stall !== exp_stall) begin
        bad++;
        $display("FAIL random_%0d got=%h st=%b want=%h st=%b",
                 i, obs_vec, obs_stall, exp_vec(), exp_stall);
      end
    end
  endtask

  initial begin
    test_reset();
    test_capture();
    test_bypass();
    test_load_use();
    test_ex_stall();
    test_flush();
    test_random();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
